// File: rtl/rv_decode_pkg.sv
// Shared opcode encodings, format codes and the decoded-field payload carried by the decode buffer.
package rv_decode_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;

  // Non-parameterised part of a buffer entry; imm and pc are stored beside it.
  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    fmt_e             fmt;
    logic             rs1_en;
    logic             rs2_en;
    logic             rd_en;
    logic             illegal;
  } dec_fields_t;

  localparam int unsigned FIELDS_W = $bits(dec_fields_t);

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I field split, immediate extraction and legality check.
// DEC_MEXT_EN adds the M-extension OP encodings and the is_muldiv_c output.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output dec_fields_t        fields_c,
  output logic [XLEN-1:0]    imm_c
`ifdef DEC_MEXT_EN
  ,output logic              is_muldiv_c
`endif
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm32;
  logic        ill;
  logic        op_base_ok;

  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign op_base_ok = (f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));

  always_comb begin
    fields_c        = '0;
    fields_c.opcode = instr[6:0];
    fields_c.funct3 = f3;
    fields_c.funct7 = f7;
    fields_c.rs1    = instr[19:15];
    fields_c.rs2    = instr[24:20];
    fields_c.rd     = instr[11:7];
    fields_c.fmt    = FMT_NONE;
    imm32           = '0;
    ill             = 1'b0;
`ifdef DEC_MEXT_EN
    is_muldiv_c     = 1'b0;
`endif

    case (instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        fields_c.fmt   = FMT_U;
        fields_c.rd_en = 1'b1;
        imm32          = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fields_c.fmt   = FMT_J;
        fields_c.rd_en = 1'b1;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        fields_c.fmt    = FMT_I;
        fields_c.rs1_en = 1'b1;
        fields_c.rd_en  = 1'b1;
        imm32           = {{20{instr[31]}}, instr[31:20]};
        ill             = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        fields_c.fmt    = FMT_B;
        fields_c.rs1_en = 1'b1;
        fields_c.rs2_en = 1'b1;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        ill   = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        fields_c.fmt    = FMT_I;
        fields_c.rs1_en = 1'b1;
        fields_c.rd_en  = 1'b1;
        imm32           = {{20{instr[31]}}, instr[31:20]};
        ill             = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        fields_c.fmt    = FMT_S;
        fields_c.rs1_en = 1'b1;
        fields_c.rs2_en = 1'b1;
        imm32           = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        ill             = (f3 >= 3'b011);
      end
      OPC_OP_IMM: begin
        fields_c.fmt    = FMT_I;
        fields_c.rs1_en = 1'b1;
        fields_c.rd_en  = 1'b1;
        imm32           = {{20{instr[31]}}, instr[31:20]};
        // Shift-immediates reuse funct7 as an operation qualifier.
        ill = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
              ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
      end
      OPC_OP: begin
        fields_c.fmt    = FMT_R;
        fields_c.rs1_en = 1'b1;
        fields_c.rs2_en = 1'b1;
        fields_c.rd_en  = 1'b1;
`ifdef DEC_MEXT_EN
        is_muldiv_c = (f7 == 7'b0000001);
        ill         = !(op_base_ok || (f7 == 7'b0000001));
`else
        ill         = !op_base_ok;
`endif
      end
      default: ill = 1'b1;
    endcase

    if (instr[1:0] != 2'b11) ill = 1'b1;
    fields_c.rd_en = fields_c.rd_en && (instr[11:7] != 5'd0);

    // Illegal entries still travel down the pipe but carry no operands.
    if (ill) begin
      fields_c.fmt    = FMT_NONE;
      fields_c.rs1_en = 1'b0;
      fields_c.rs2_en = 1'b0;
      fields_c.rd_en  = 1'b0;
      imm32           = '0;
`ifdef DEC_MEXT_EN
      is_muldiv_c     = 1'b0;
`endif
    end
    fields_c.illegal = ill;
  end

  assign imm_c = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: decodes on push and queues results with PC in a small FIFO.
// Optional macro DEC_MEXT_EN enables M-extension decode and the out_is_muldiv port.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [6:0]         out_opcode,
  output logic [2:0]         out_funct3,
  output logic [6:0]         out_funct7,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_rd,
  output logic [XLEN-1:0]    out_imm,
  output logic [2:0]         out_fmt,
  output logic               out_rs1_en,
  output logic               out_rs2_en,
  output logic               out_rd_en,
  output logic               out_illegal
`ifdef DEC_MEXT_EN
  ,output logic              out_is_muldiv
`endif
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

  dec_fields_t         dec_fields;
  logic [XLEN-1:0]     dec_imm;
  dec_fields_t         ent_fields [BUF_DEPTH];
  logic [XLEN-1:0]     ent_imm    [BUF_DEPTH];
  logic [PC_W-1:0]     ent_pc     [BUF_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_nxt;
  logic                push;
  logic                pop;
  dec_fields_t         head;

`ifdef DEC_MEXT_EN
  logic                dec_muldiv;
  logic                ent_muldiv [BUF_DEPTH];
`endif

  rv_decode_comb #(.XLEN(XLEN)) u_comb (
    .instr       (in_instr),
    .fields_c    (dec_fields),
    .imm_c       (dec_imm)
`ifdef DEC_MEXT_EN
    ,.is_muldiv_c(dec_muldiv)
`endif
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Flush has priority over any simultaneous push or pop.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      in_ready  <= (count_nxt < CNT_FULL);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Entry storage is cleared on reset so the output data reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        ent_fields[i] <= '0;
        ent_imm[i]    <= '0;
        ent_pc[i]     <= '0;
`ifdef DEC_MEXT_EN
        ent_muldiv[i] <= 1'b0;
`endif
      end
    end else if (push && !flush) begin
      ent_fields[wr_ptr] <= dec_fields;
      ent_imm[wr_ptr]    <= dec_imm;
      ent_pc[wr_ptr]     <= in_pc;
`ifdef DEC_MEXT_EN
      ent_muldiv[wr_ptr] <= dec_muldiv;
`endif
    end
  end

  assign head        = ent_fields[rd_ptr];
  assign out_pc      = ent_pc[rd_ptr];
  assign out_imm     = ent_imm[rd_ptr];
  assign out_opcode  = head.opcode;
  assign out_funct3  = head.funct3;
  assign out_funct7  = head.funct7;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_fmt     = head.fmt;
  assign out_rs1_en  = head.rs1_en;
  assign out_rs2_en  = head.rs2_en;
  assign out_rd_en   = head.rd_en;
  assign out_illegal = head.illegal;
`ifdef DEC_MEXT_EN
  assign out_is_muldiv = ent_muldiv[rd_ptr];
`endif

endmodule
